// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline types: pixel record and pixel FIFO issue states.
package gfx_pkg;

  localparam int unsigned GFX_POINT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } pixel_fifo_state_e;

  typedef struct packed {
    logic [GFX_POINT_W-1:0] x;
    logic [GFX_POINT_W-1:0] y;
    logic [GFX_POINT_W-1:0] z;
    logic [31:0]            color;
  } gfx_pixel_t;

endpackage

// File: rtl/gfx_sync_fifo.sv
// Generic synchronous FIFO with AW+1-bit wrap-tagged pointers and flush.
module gfx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Pointer update; flush returns both pointers to zero and overrides push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gfx_pixel_fifo.sv
// Pixel buffer between rasterizer and renderer: optional bounds clip at push,
// then one pixel at a time is issued with a single-cycle write pulse and held
// until the renderer acknowledges it.
module gfx_pixel_fifo
  import gfx_pkg::*;
#(
  parameter int unsigned point_width = 16,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  input  logic                   clip_enable_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  output logic                   ready_o,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [31:0]            color_i,
  output logic [point_width-1:0] pixel_x_o,
  output logic [point_width-1:0] pixel_y_o,
  output logic [point_width-1:0] pixel_z_o,
  output logic [31:0]            color_o,
  output logic                   write_o,
  input  logic                   ack_i,
  output logic [AW:0]            count_o,
  output logic                   busy_o,
  output logic [15:0]            drop_count_o
);

  localparam int unsigned PW = 3 * point_width + 32;

  pixel_fifo_state_e state;
  logic              full;
  logic              empty;
  logic              accept;
  logic              clipped;
  logic              store;
  logic              pop;
  logic [PW-1:0]     wdata;
  logic [PW-1:0]     rdata;

  assign ready_o = ~full;
  assign accept  = push_i & ~full & ~flush_i;
  assign clipped = clip_enable_i &
                   ((pixel_x_i >= target_size_x_i) | (pixel_y_i >= target_size_y_i));
  assign store   = accept & ~clipped;
  assign pop     = (state == IDLE) & ~empty & ~flush_i;
  assign wdata   = {pixel_x_i, pixel_y_i, pixel_z_i, color_i};
  assign busy_o  = ~empty | (state != IDLE);

  gfx_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (store),
    .pop   (pop),
    .flush (flush_i),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  // Saturating count of accepted-but-clipped pixels.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      drop_count_o <= '0;
    end else if (accept && clipped && (drop_count_o != '1)) begin
      drop_count_o <= drop_count_o + 16'd1;
    end
  end

  // Issue FSM: pop into output registers, pulse write once, wait for ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      write_o   <= 1'b0;
      pixel_x_o <= '0;
      pixel_y_o <= '0;
      pixel_z_o <= '0;
      color_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {pixel_x_o, pixel_y_o, pixel_z_o, color_o} <= rdata;
            write_o <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          write_o <= 1'b0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_i) state <= IDLE;
        end
        default: begin
          write_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_pixel_fifo.sv
// Scoreboard bench for gfx_pixel_fifo: stimulus queues expected pixels, a
// monitor pops and compares on every write pulse, a renderer model acks.
module tb_gfx_pixel_fifo;
  import gfx_pkg::*;

  logic        clk;
  logic        rst_i;
  logic [15:0] target_size_x_i;
  logic [15:0] target_size_y_i;
  logic        clip_enable_i;
  logic        flush_i;
  logic        push_i;
  logic        ready_o;
  logic [15:0] pixel_x_i, pixel_y_i, pixel_z_i;
  logic [31:0] color_i;
  logic [15:0] pixel_x_o, pixel_y_o, pixel_z_o;
  logic [31:0] color_o;
  logic        write_o;
  logic        ack_i;
  logic [4:0]  count_o;
  logic        busy_o;
  logic [15:0] drop_count_o;

  gfx_pixel_fifo #(
    .point_width (16),
    .DEPTH       (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .target_size_x_i (target_size_x_i),
    .target_size_y_i (target_size_y_i),
    .clip_enable_i   (clip_enable_i),
    .flush_i         (flush_i),
    .push_i          (push_i),
    .ready_o         (ready_o),
    .pixel_x_i       (pixel_x_i),
    .pixel_y_i       (pixel_y_i),
    .pixel_z_i       (pixel_z_i),
    .color_i         (color_i),
    .pixel_x_o       (pixel_x_o),
    .pixel_y_o       (pixel_y_o),
    .pixel_z_o       (pixel_z_o),
    .color_o         (color_o),
    .write_o         (write_o),
    .ack_i           (ack_i),
    .count_o         (count_o),
    .busy_o          (busy_o),
    .drop_count_o    (drop_count_o)
  );

  int          checks = 0;
  int          errors = 0;
  int          writes_seen = 0;
  bit          auto_ack = 0;
  bit          rand_ack = 0;
  bit          manual_ack = 0;
  gfx_pixel_t  exp_q[$];
  gfx_pixel_t  cur;

  assign cur = {pixel_x_o, pixel_y_o, pixel_z_o, color_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue.
  initial begin
    gfx_pixel_t e;
    forever begin
      @(negedge clk);
      if (write_o === 1'b1) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 80'(cur), 80'(0));
          if (cur == 80'(0)) begin
            errors++;
            $display("FAIL unexpected_write: got write_o=1 expected no write");
          end
        end else begin
          e = exp_q.pop_front();
          check("issued_pixel", 80'(cur), 80'(e));
        end
      end
    end
  end

  // Renderer model: manual single ack, or automatic ack after each write.
  initial begin
    gfx_pixel_t snap;
    int unsigned d;
    ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (manual_ack) begin
        ack_i = 1'b1;
        manual_ack = 0;
        @(negedge clk);
        ack_i = 1'b0;
      end else if (auto_ack && write_o === 1'b1) begin
        snap = cur;
        d = rand_ack ? $urandom_range(0, 6) : 0;
        @(negedge clk);
        check("write_one_cycle", 80'(write_o), 80'(0));
        repeat (d) @(negedge clk);
        ack_i = 1'b1;
        check("hold_until_ack", 80'(cur), 80'(snap));
        @(negedge clk);
        ack_i = 1'b0;
      end
    end
  end

  // Drive one push for one cycle, starting at a negedge; ends at next negedge.
  task automatic drive_push(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input logic [31:0] c, input bit stored);
    gfx_pixel_t p;
    p = {x, y, z, c};
    pixel_x_i = x; pixel_y_i = y; pixel_z_i = z; color_i = c;
    push_i = 1'b1;
    if (stored) exp_q.push_back(p);
    @(negedge clk);
    push_i = 1'b0;
  endtask

  task automatic push_when_ready(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                 input logic [31:0] c);
    int unsigned n = 0;
    while (ready_o !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait_timeout", 80'(n < 500), 80'(1));
    drive_push(x, y, z, c, 1'b1);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 80'(n < 3000), 80'(1));
  endtask

  task automatic do_manual_ack();
    @(posedge clk);
    manual_ack = 1;
    wait (manual_ack == 0);
  endtask

  initial begin
    rst_i = 1'b0;
    target_size_x_i = 16'hFFFF; target_size_y_i = 16'hFFFF;
    clip_enable_i = 1'b0; flush_i = 1'b0; push_i = 1'b0;
    pixel_x_i = '0; pixel_y_i = '0; pixel_z_i = '0; color_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_write", 80'(write_o), 80'(0));
    check("rst_ready", 80'(ready_o), 80'(1));
    check("rst_busy", 80'(busy_o), 80'(0));
    check("rst_count", 80'(count_o), 80'(0));
    check("rst_drop", 80'(drop_count_o), 80'(0));
    check("rst_pixel", 80'(cur), 80'(0));

    // Single pixel: latency N+2, hold until ack, then idle
    drive_push(16'd3, 16'd5, 16'd7, 32'h00FF00FF, 1'b1);
    check("lat_n1_write", 80'(write_o), 80'(0));
    check("lat_n1_count", 80'(count_o), 80'(1));
    @(negedge clk);
    check("lat_n2_write", 80'(write_o), 80'(1));
    @(negedge clk);
    check("single_pulse", 80'(write_o), 80'(0));
    repeat (3) @(negedge clk);
    check("single_hold", 80'(cur), 80'({16'd3, 16'd5, 16'd7, 32'h00FF00FF}));
    check("single_busy", 80'(busy_o), 80'(1));
    do_manual_ack();
    check("single_ack_hold", 80'(cur), 80'({16'd3, 16'd5, 16'd7, 32'h00FF00FF}));
    @(negedge clk);
    check("single_idle_busy", 80'(busy_o), 80'(0));

    // Fill: one pixel in flight plus 16 queued; 17th refused
    drive_push(16'd1000, 16'd1, 16'd1, 32'hF0000000, 1'b1);
    repeat (3) @(negedge clk);
    for (int unsigned i = 0; i < 16; i++)
      drive_push(16'(i), 16'(i + 20), 16'(i + 40), 32'hF1000000 | i, 1'b1);
    check("fill_count", 80'(count_o), 80'(16));
    check("fill_ready", 80'(ready_o), 80'(0));
    drive_push(16'd999, 16'd999, 16'd999, 32'hDEADBEEF, 1'b0);
    check("fill_refused_count", 80'(count_o), 80'(16));
    auto_ack = 1;
    do_manual_ack();
    wait_drain();
    check("fill_ready_after", 80'(ready_o), 80'(1));

    // Clip: 100x50 window, only (99,49) survives; then clip off passes all
    target_size_x_i = 16'd100; target_size_y_i = 16'd50; clip_enable_i = 1'b1;
    drive_push(16'd100, 16'd0, 16'd2, 32'h11111111, 1'b0);
    drive_push(16'd0, 16'd50, 16'd2, 32'h22222222, 1'b0);
    drive_push(16'd99, 16'd49, 16'd2, 32'h33333333, 1'b1);
    wait_drain();
    check("clip_drop_count", 80'(drop_count_o), 80'(2));
    clip_enable_i = 1'b0;
    drive_push(16'd100, 16'd0, 16'd2, 32'h11111111, 1'b1);
    drive_push(16'd0, 16'd50, 16'd2, 32'h22222222, 1'b1);
    drive_push(16'd99, 16'd49, 16'd2, 32'h33333333, 1'b1);
    wait_drain();
    check("noclip_drop_count", 80'(drop_count_o), 80'(2));

    // Flush: 5 queued, 1 in flight; same-cycle push blocked
    auto_ack = 0;
    for (int unsigned i = 0; i < 6; i++)
      drive_push(16'(i + 200), 16'd8, 16'd9, 32'hC0000000 | i, 1'b1);
    repeat (3) @(negedge clk);
    check("flush_pre_count", 80'(count_o), 80'(5));
    flush_i = 1'b1;
    exp_q.delete();
    drive_push(16'd777, 16'd7, 16'd7, 32'h77777777, 1'b0);
    flush_i = 1'b0;
    check("flush_count", 80'(count_o), 80'(0));
    check("flush_busy_inflight", 80'(busy_o), 80'(1));
    repeat (3) @(negedge clk);
    check("flush_inflight_hold", 80'(cur), 80'({16'd200, 16'd8, 16'd9, 32'hC0000000}));
    do_manual_ack();
    repeat (6) @(negedge clk);
    check("flush_idle_busy", 80'(busy_o), 80'(0));

    // Wrap: 40 pixels streamed with random ack delays
    auto_ack = 1; rand_ack = 1;
    writes_seen = 0;
    for (int unsigned i = 0; i < 40; i++)
      push_when_ready(16'(i), 16'(i + 100), 16'(16'hFFFF - i), 32'hA5000000 | i);
    wait_drain();
    check("wrap_write_total", 80'(writes_seen), 80'(40));

    // Reset during WAIT_ACK: async clear, later ack ignored
    auto_ack = 0; rand_ack = 0;
    drive_push(16'd55, 16'd66, 16'd77, 32'h12345678, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    check("arst_write", 80'(write_o), 80'(0));
    check("arst_ready", 80'(ready_o), 80'(1));
    check("arst_busy", 80'(busy_o), 80'(0));
    check("arst_count", 80'(count_o), 80'(0));
    check("arst_drop", 80'(drop_count_o), 80'(0));
    check("arst_pixel", 80'(cur), 80'(0));
    @(negedge clk);
    rst_i = 1'b1;
    do_manual_ack();
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_write", 80'(write_o), 80'(0));
      check("post_rst_busy", 80'(busy_o), 80'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
